// File: rtl/temp_storage_pkg.sv
// Types shared between pipeline stages: the IF->ID bundle and the fetch FSM encoding.
package temp_storage;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic  inst_signal;
    inst_t inst;
    addr_t inst_pc;
  } if_id_t;

  typedef enum logic [1:0] {FETCH_REQ, FETCH_HOLD, FETCH_DRAIN} fetch_state_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch.sv
// IF stage: keeps the PC, issues one outstanding instruction-bus request at a time and
// drives the registered IF/ID bundle, honouring ID stall and EX redirects.
module inst_fetch
  import temp_storage::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic                       ireq_valid,
  output logic [63:0]                ireq_addr,
  input  logic                       iresp_data_ok,
  input  logic [31:0]                iresp_data,
  output logic [$bits(if_id_t)-1:0]  if_id_out,
  output logic                       fetch_busy
);

  fetch_state_t r_state, w_state;
  addr_t        r_pc, w_pc;
  addr_t        r_addr_q, w_addr_q;
  inst_t        r_buf_inst, w_buf_inst;
  addr_t        r_buf_pc, w_buf_pc;
  if_id_t       r_out, w_out;
  addr_t        w_pc_inc;

  function automatic addr_t pc_step(input addr_t pc);
    return pc + addr_t'(INST_BYTES);
  endfunction

  assign w_pc_inc = pc_step(r_pc);

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_addr_q   = r_addr_q;
    w_buf_inst = r_buf_inst;
    w_buf_pc   = r_buf_pc;
    w_out      = r_out;
    if (!stall) w_out.inst_signal = 1'b0;

    if (redirect_valid) begin
      // A redirect flushes ID even under stall; a request still on the bus must be drained.
      w_pc              = redirect_pc;
      w_out.inst_signal = 1'b0;
      if ((r_state != FETCH_HOLD) && !iresp_data_ok) begin
        w_state = FETCH_DRAIN;
      end else begin
        w_state  = FETCH_REQ;
        w_addr_q = redirect_pc;
      end
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (iresp_data_ok) begin
            w_pc     = w_pc_inc;
            w_addr_q = w_pc_inc;
            if (stall) begin
              w_buf_inst = iresp_data;
              w_buf_pc   = r_pc;
              w_state    = FETCH_HOLD;
            end else begin
              w_out = '{inst_signal: 1'b1, inst: iresp_data, inst_pc: r_pc};
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            w_out   = '{inst_signal: 1'b1, inst: r_buf_inst, inst_pc: r_buf_pc};
            w_state = FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (iresp_data_ok) begin
            w_addr_q = r_pc;
            w_state  = FETCH_REQ;
          end
        end
        default: w_state = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= FETCH_REQ;
      r_pc       <= RESET_PC;
      r_addr_q   <= RESET_PC;
      r_buf_inst <= '0;
      r_buf_pc   <= '0;
      r_out      <= '0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_addr_q   <= w_addr_q;
      r_buf_inst <= w_buf_inst;
      r_buf_pc   <= w_buf_pc;
      r_out      <= w_out;
    end
  end

  assign ireq_valid = reset_n && (r_state != FETCH_HOLD);
  assign fetch_busy = reset_n && (r_state != FETCH_HOLD);
  assign ireq_addr  = r_addr_q;
  assign if_id_out  = r_out;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: bus responder with variable latency, in-order PC stream model,
// directed scenarios followed by randomized stall/redirect/reset traffic.
module tb_inst_fetch;

  localparam logic [63:0] RST_PC  = 64'h8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid, iresp_data_ok, fetch_busy;
  logic [63:0] ireq_addr;
  logic [31:0] iresp_data;
  logic [96:0] if_id_out;

  logic        wr_ireq_valid, wr_busy;
  logic [63:0] wr_ireq_addr;
  logic [96:0] wr_out;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int lat_cfg = 0;
  int bus_wait = 0;
  logic [63:0] exp_pc = RST_PC;
  logic        pv_rn = 1'b1, pv_st = 1'b0, pv_rv = 1'b0, pv_iv = 1'b0, pv_ok = 1'b0;
  logic [63:0] pv_addr = '0;
  logic [96:0] pv_out = '0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .if_id_out(if_id_out),
    .fetch_busy(fetch_busy)
  );

  inst_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(64'h0), .ireq_valid(wr_ireq_valid), .ireq_addr(wr_ireq_addr),
    .iresp_data_ok(wr_ireq_valid), .iresp_data(32'h0000_0013), .if_id_out(wr_out),
    .fetch_busy(wr_busy)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
  endfunction

  function automatic int new_lat();
    return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer the bus, then check against the PC-stream model.
  task automatic step(input logic rn, input logic st, input logic rv, input logic [63:0] rpc);
    @(posedge clk);
    #1;
    reset_n = rn; stall = st; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (ireq_valid && bus_wait == 0) begin
      iresp_data_ok = 1'b1;
      iresp_data    = mem(ireq_addr);
    end else begin
      iresp_data_ok = 1'b0;
      iresp_data    = $urandom;
      if (ireq_valid) bus_wait--;
    end
    #1;
    if (!rn) chk("rst_ireq_valid", ireq_valid, 0);
    else     chk("busy", fetch_busy, ireq_valid);
    if (!pv_rn) begin
      chk("rst_out", if_id_out, 0);
      if (rn) chk("rst_req", {ireq_valid, ireq_addr}, {1'b1, RST_PC});
    end else begin
      if (pv_rv)      chk("flush", if_id_out[96], 0);
      else if (pv_st) chk("hold", if_id_out, pv_out);
      if (pv_iv && !pv_ok && rn) chk("req_held", {ireq_valid, ireq_addr}, {1'b1, pv_addr});
    end
    if (rn && !rv && if_id_out[96] && !st) begin
      chk("pc", if_id_out[63:0], exp_pc);
      chk("inst", if_id_out[95:64], mem(exp_pc));
      exp_pc = exp_pc + 64'd4;
      delivered++;
    end
    if (!rn)     exp_pc = RST_PC;
    else if (rv) exp_pc = rpc;
    if (!rn || iresp_data_ok) bus_wait = new_lat();
    pv_rn = rn; pv_st = st; pv_rv = rv; pv_iv = ireq_valid; pv_ok = iresp_data_ok;
    pv_addr = ireq_addr; pv_out = if_id_out;
  endtask

  initial begin
    logic [63:0] rpc;
    logic        rn, st, rv;
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    iresp_data_ok = 1'b0; iresp_data = '0;

    // Reset, zero-latency bus, no stall
    lat_cfg = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t1_a0", ireq_addr, RST_PC);
    chk("t1_sig0", if_id_out[96], 0);
    chk("wrap_a0", wr_ireq_addr, WRAP_PC);
    step(1, 0, 0, 0);
    chk("t1_a1", ireq_addr, 64'h8000_0004);
    chk("t1_out1", {if_id_out[96], if_id_out[63:0]}, {1'b1, RST_PC});
    chk("wrap_a1", wr_ireq_addr, 64'h0);
    chk("wrap_out1", {wr_out[96], wr_out[63:0]}, {1'b1, WRAP_PC});
    step(1, 0, 0, 0);
    chk("t1_a2", ireq_addr, 64'h8000_0008);
    chk("t1_out2", {if_id_out[96], if_id_out[63:0]}, {1'b1, 64'h8000_0004});
    chk("wrap_out2", wr_out[63:0], 64'h0);

    // Stall while data arrives
    step(1, 1, 0, 0);
    chk("t2_pc", if_id_out[63:0], 64'h8000_0008);
    step(1, 1, 0, 0);
    chk("t2_hold_iv", ireq_valid, 0);
    step(1, 1, 0, 0);
    chk("t2_hold_iv2", ireq_valid, 0);
    step(1, 0, 0, 0);
    chk("t2_rel_iv", ireq_valid, 0);
    lat_cfg = 2;
    step(1, 0, 0, 0);
    chk("t2_buf", {if_id_out[96], if_id_out[63:0]}, {1'b1, 64'h8000_000C});
    chk("t2_next", ireq_addr, 64'h8000_0010);

    // Redirect with a request pending on a 3-cycle bus
    step(1, 0, 1, 64'h8000_0100);
    chk("t3_pend", {ireq_valid, iresp_data_ok, ireq_addr}, {2'b10, 64'h8000_0014});
    step(1, 0, 0, 0);
    chk("t3_stale", ireq_addr, 64'h8000_0014);
    lat_cfg = 0;
    step(1, 0, 0, 0);
    chk("t3_drop_ok", iresp_data_ok, 1);
    step(1, 0, 0, 0);
    chk("t3_target", ireq_addr, 64'h8000_0100);
    chk("t3_no_stale", if_id_out[96], 0);

    // Redirect coinciding with data_ok
    step(1, 0, 1, 64'h8000_0200);
    chk("t4_same", {iresp_data_ok, if_id_out[63:0]}, {1'b1, 64'h8000_0100});
    step(1, 0, 0, 0);
    chk("t4_target", {ireq_addr, if_id_out[96]}, {64'h8000_0200, 1'b0});

    // Redirect under stall with a valid instruction in ID
    step(1, 1, 1, 64'h8000_0300);
    chk("t5_valid", {if_id_out[96], if_id_out[63:0]}, {1'b1, 64'h8000_0200});
    lat_cfg = 3;
    step(1, 1, 0, 0);
    chk("t5_flush", {if_id_out[96], ireq_addr}, {1'b0, 64'h8000_0300});

    // Reset in the middle of a request
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_rst_iv", ireq_valid, 0);
    step(1, 0, 0, 0);
    chk("t6_restart", {ireq_valid, ireq_addr}, {1'b1, RST_PC});

    // Randomized traffic
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        1:       rpc = 64'h8000_1000 + 64'($urandom_range(0, 15));
        default: rpc = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
      endcase
      step(rn, st, rv, rpc);
    end
    chk("progress", delivered >= 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
